// File: rtl/modulation_pkg.sv
// modulation_pkg: shared state encoding and widths for the modulation buffer loader
package modulation_pkg;
  typedef enum logic [1:0] {IDLE, LO, HI, COMMIT} state_e;
  localparam int MOD_CYCLE_W = 16;
  localparam int DEFAULT_ADDR_W = 16;
endpackage

// File: rtl/modulation_loader.sv
// modulation_loader: unpacks 16-bit words into byte writes of the modulation BRAM and publishes MOD_CYCLE
module modulation_loader
  import modulation_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   START,
  input  logic                   WR_VALID,
  output logic                   WR_READY,
  input  logic [15:0]            WR_DATA,
  input  logic                   WR_LAST,
  input  logic                   WR_ODD,
  output logic                   BRAM_WE,
  output logic [ADDR_W-1:0]      BRAM_ADDR,
  output logic [7:0]             BRAM_DIN,
  output logic [MOD_CYCLE_W-1:0] MOD_CYCLE,
  output logic                   CYCLE_UPDATE,
  output logic                   OVERFLOW
);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d, addr_d;
  logic full_q, full_d, last_q, last_d;
  logic [7:0] hi_q, hi_d, wdata, din_d;
  logic [MOD_CYCLE_W-1:0] mc_d;
  logic hs, wr, ready_d, we_d, upd_d, ovf_d;

  always_comb begin
    hs = WR_VALID && WR_READY && !START && state_q == LO;
    wr = hs || (state_q == HI && !START);
    wdata = state_q == HI ? hi_q : WR_DATA[7:0];
    state_d = START ? LO :
      state_q == LO ? (hs ? (WR_LAST && WR_ODD ? COMMIT : HI) : LO) :
      state_q == HI ? (last_q ? COMMIT : LO) : IDLE;
    // the pointer saturates at the last address; full marks that it has been written
    ptr_d = START ? '0 : (wr && !full_q && !(&ptr_q)) ? ptr_q + ADDR_W'(1) : ptr_q;
    full_d = !START && (full_q || (wr && &ptr_q));
    ovf_d = !START && (OVERFLOW || (wr && full_q));
    hi_d = hs ? WR_DATA[15:8] : hi_q;
    last_d = hs ? WR_LAST : last_q;
    we_d = wr && !full_q;
    addr_d = wr ? ptr_q : BRAM_ADDR;
    din_d = wr ? wdata : BRAM_DIN;
    upd_d = state_q == COMMIT;
    mc_d = upd_d ? MOD_CYCLE_W'(full_q ? ptr_q : ptr_q - ADDR_W'(1)) : MOD_CYCLE;
    ready_d = state_d == LO && !START;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      ptr_q <= '0;
      full_q <= 1'b0;
      hi_q <= '0;
      last_q <= 1'b0;
      WR_READY <= 1'b0;
      BRAM_WE <= 1'b0;
      BRAM_ADDR <= '0;
      BRAM_DIN <= '0;
      MOD_CYCLE <= '0;
      CYCLE_UPDATE <= 1'b0;
      OVERFLOW <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      full_q <= full_d;
      hi_q <= hi_d;
      last_q <= last_d;
      WR_READY <= ready_d;
      BRAM_WE <= we_d;
      BRAM_ADDR <= addr_d;
      BRAM_DIN <= din_d;
      MOD_CYCLE <= mc_d;
      CYCLE_UPDATE <= upd_d;
      OVERFLOW <= ovf_d;
    end
  end
endmodule

// File: tb/tb_modulation_loader.sv
// tb_modulation_loader: random word streams into 16-bit and 4-bit address instances, scoreboarded writes and commits
module tb_modulation_loader;
  typedef struct { int a; int d; } wr_t;
  typedef struct { int mc16; int mc4; bit ov16; bit ov4; int at; } cm_t;
  logic CLK = 0, RST = 1, START = 0, WR_VALID = 0, WR_LAST = 0, WR_ODD = 0;
  logic [15:0] WR_DATA = 0;
  logic rdy16, we16, upd16, ovf16, rdy4, we4, upd4, ovf4;
  logic [15:0] addr16, mc16, mc4;
  logic [3:0] addr4;
  logic [7:0] din16, din4;
  int total = 0, bad = 0, edge_n = 0, cnt16 = 0, cnt4 = 0, exp16 = 0, exp4 = 0;
  bit ov16 = 0, ov4 = 0, mon_en = 0, eu;
  wr_t q16[$], q4[$], w;
  cm_t qc[$], c;
  logic [15:0] ws[12];

  always #5 CLK = ~CLK;
  always @(posedge CLK) edge_n <= edge_n + 1;

  modulation_loader #(.ADDR_W(16)) dut16 (.CLK(CLK), .RST(RST), .START(START), .WR_VALID(WR_VALID),
    .WR_READY(rdy16), .WR_DATA(WR_DATA), .WR_LAST(WR_LAST), .WR_ODD(WR_ODD), .BRAM_WE(we16),
    .BRAM_ADDR(addr16), .BRAM_DIN(din16), .MOD_CYCLE(mc16), .CYCLE_UPDATE(upd16), .OVERFLOW(ovf16));
  modulation_loader #(.ADDR_W(4)) dut4 (.CLK(CLK), .RST(RST), .START(START), .WR_VALID(WR_VALID),
    .WR_READY(rdy4), .WR_DATA(WR_DATA), .WR_LAST(WR_LAST), .WR_ODD(WR_ODD), .BRAM_WE(we4),
    .BRAM_ADDR(addr4), .BRAM_DIN(din4), .MOD_CYCLE(mc4), .CYCLE_UPDATE(upd4), .OVERFLOW(ovf4));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (edge %0d)", nm, act, exp, edge_n);
    end
  endtask

  task automatic put(input logic [7:0] s);
    if (cnt16 < 65536) begin q16.push_back('{cnt16, int'(s)}); cnt16++; end else ov16 = 1;
    if (cnt4 < 16) begin q4.push_back('{cnt4, int'(s)}); cnt4++; end else ov4 = 1;
  endtask

  task automatic start(input bit vld);
    START = 1;
    if (vld) begin WR_VALID = 1; WR_DATA = 16'hEEEE; WR_LAST = 0; WR_ODD = 0; end
    @(posedge CLK); #1;
    START = 0; WR_VALID = 0;
    cnt16 = 0; cnt4 = 0; ov16 = 0; ov4 = 0;
    chk("rdy_after_start", rdy16, 0);
    chk("ovf4_cleared", ovf4, 0);
    @(posedge CLK); #1;
    chk("rdy_in_lo", rdy16, 1);
  endtask

  task automatic send(input logic [15:0] d, input bit l, input bit o, input bit gaps);
    int n = 0;
    if (gaps) repeat ($urandom_range(0, 3)) begin @(posedge CLK); #1; end
    WR_VALID = 1; WR_DATA = d; WR_LAST = l; WR_ODD = o;
    while (!rdy16 && n < 20) begin @(posedge CLK); #1; n++; end
    if (!rdy16) begin chk("ready_timeout", rdy16, 1); WR_VALID = 0; return; end
    @(posedge CLK); #1;
    WR_VALID = 0;
    put(d[7:0]);
    if (!(l && o)) put(d[15:8]);
    if (l) qc.push_back('{cnt16 - 1, cnt4 - 1, ov16, ov4, edge_n + ((l && o) ? 1 : 2)});
  endtask

  task automatic settle();
    repeat (5) begin @(posedge CLK); #1; end
  endtask

  task automatic chk_reset();
    chk("rst_rdy16", rdy16, 0); chk("rst_we16", we16, 0); chk("rst_addr16", addr16, 0);
    chk("rst_din16", din16, 0); chk("rst_mc16", mc16, 0); chk("rst_upd16", upd16, 0);
    chk("rst_ovf16", ovf16, 0); chk("rst_rdy4", rdy4, 0); chk("rst_we4", we4, 0);
    chk("rst_addr4", addr4, 0); chk("rst_din4", din4, 0); chk("rst_mc4", mc4, 0);
    chk("rst_upd4", upd4, 0); chk("rst_ovf4", ovf4, 0);
  endtask

  always @(negedge CLK) if (mon_en) begin
    if (we16) begin
      chk("wr16_pending", q16.size() > 0, 1);
      if (q16.size() > 0) begin w = q16.pop_front(); chk("wr16_addr", addr16, w.a); chk("wr16_data", din16, w.d); end
    end
    if (we4) begin
      chk("wr4_pending", q4.size() > 0, 1);
      if (q4.size() > 0) begin w = q4.pop_front(); chk("wr4_addr", addr4, w.a); chk("wr4_data", din4, w.d); end
    end
    eu = qc.size() > 0 && qc[0].at == edge_n;
    chk("upd16", upd16, eu);
    chk("upd4", upd4, eu);
    if (eu) begin
      c = qc.pop_front();
      exp16 = c.mc16; exp4 = c.mc4;
      chk("ovf16", ovf16, c.ov16);
      chk("ovf4", ovf4, c.ov4);
    end
    chk("mc16", mc16, exp16);
    chk("mc4", mc4, exp4);
  end

  initial begin
    int n;
    bit odd;
    repeat (2) @(posedge CLK);
    #1 RST = 0;
    chk_reset();
    mon_en = 1;
    WR_VALID = 1; WR_DATA = 16'h1234;
    repeat (6) begin @(posedge CLK); #1; chk("idle_rdy16", rdy16, 0); chk("idle_rdy4", rdy4, 0); end
    WR_VALID = 0;
    start(0);
    send(16'h0201, 0, 0, 0); send(16'h0403, 0, 0, 0); send(16'h0605, 1, 0, 0); settle();
    start(0);
    send(16'hBBAA, 0, 0, 0); send(16'h00CC, 1, 1, 0); settle();
    start(0);
    for (int i = 0; i < 10; i++) send(16'($urandom), i == 9, 0, 0);
    settle();
    start(0);
    send(16'h0201, 0, 0, 0); send(16'h0403, 0, 0, 0); send(16'h0605, 1, 0, 0); settle();
    start(0);
    send(16'h1111, 0, 0, 0); send(16'h2222, 0, 0, 0);
    repeat (3) begin @(posedge CLK); #1; end
    start(1);
    send(16'h3344, 1, 0, 0); settle();
    repeat (4) begin
      n = $urandom_range(1, 12);
      odd = 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) ws[i] = 16'($urandom);
      for (int g = 0; g < 2; g++) begin
        start(0);
        for (int i = 0; i < n; i++)
          send(ws[i], i == n - 1, (i == n - 1) ? odd : 1'($urandom_range(0, 1)), g == 1);
        settle();
      end
    end
    start(0);
    send(16'h5566, 0, 0, 0);
    RST = 1;
    @(negedge CLK);
    @(posedge CLK); #1;
    RST = 0;
    q16.delete(); q4.delete(); qc.delete();
    cnt16 = 0; cnt4 = 0; ov16 = 0; ov4 = 0; exp16 = 0; exp4 = 0;
    chk_reset();
    repeat (3) begin @(posedge CLK); #1; chk("post_rst_idle", rdy16, 0); end
    chk("q16_drained", q16.size(), 0);
    chk("q4_drained", q4.size(), 0);
    chk("commits_drained", qc.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
